// File: rtl/regdump_pkg.sv
// Shared FSM encoding and default widths for the register-file dump reader.
package regdump_pkg;

   localparam int N_DEF        = 32;
   localparam int ADDR_W_DEF   = 5;
   localparam int NUM_REGS_DEF = 32;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      SEND,
      CSUM,
      DONE
   } state_t;

endpackage

// File: rtl/regdump_index_counter.sv
// Register index walker: clear, saturating increment, at-last-index flag.
// Single-cycle update; saturates at NUM_REGS-1 and never wraps.
module regdump_index_counter
   import regdump_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int NUM_REGS = NUM_REGS_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              incr,
   output logic [ADDR_W-1:0] idx,
   output logic              at_last
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx <= '0;
      end else if (clear) begin
         idx <= '0;
      end else if (incr && (idx != LAST_IDX)) begin
         idx <= idx + 1'b1;
      end
   end

   assign at_last = (idx == LAST_IDX);

endmodule

// File: rtl/regfile_dump_reader.sv
// Streams every register-file word with its index; optional XOR checksum word (REGDUMP_CHECKSUM_EN).
// Latency: start edge -> FETCH -> SEND, 2 cycles per word with dump_ready high.
// Backpressure: SEND holds data/index/last stable until dump_valid & dump_ready.
module regfile_dump_reader
   import regdump_pkg::*;
#(
   parameter int N        = N_DEF,
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int ADDR_W   = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [ADDR_W-1:0] rf_read_addr,
   input  logic [N-1:0]      rf_read_data,
   output logic [N-1:0]      dump_data,
   output logic [ADDR_W-1:0] dump_index,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic              dump_last,
   output logic              busy,
   output logic              done
);

`ifdef REGDUMP_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif

   state_t            state;
   logic [ADDR_W-1:0] idx;
   logic              at_last;
   logic              idx_clear;
   logic              idx_incr;

   // Clearing in DONE leaves the read port parked at index 0 while idle.
   assign idx_clear = ((state == IDLE) && start) || (state == DONE);
   assign idx_incr  = (state == SEND) && dump_ready && !at_last;

   regdump_index_counter #(
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS)
   ) u_index_counter (
      .clk     (clk),
      .reset   (reset),
      .clear   (idx_clear),
      .incr    (idx_incr),
      .idx     (idx),
      .at_last (at_last)
   );

   assign rf_read_addr = idx;

`ifdef REGDUMP_CHECKSUM_EN
   logic [N-1:0] csum;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         csum <= '0;
      end else if ((state == IDLE) && start) begin
         csum <= '0;
      end else if (state == FETCH) begin
         csum <= csum ^ rf_read_data;
      end
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         dump_data  <= '0;
         dump_index <= '0;
         dump_valid <= 1'b0;
         dump_last  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= FETCH;
                  busy  <= 1'b1;
               end
            end
            FETCH: begin
               dump_data  <= rf_read_data;
               dump_index <= idx;
               dump_valid <= 1'b1;
               dump_last  <= at_last && !CSUM_EN;
               state      <= SEND;
            end
            SEND: begin
               if (dump_ready) begin
                  if (at_last) begin
`ifdef REGDUMP_CHECKSUM_EN
                     state      <= CSUM;
                     dump_data  <= csum;
                     dump_index <= '0;
                     dump_last  <= 1'b1;
`else
                     state      <= DONE;
                     dump_valid <= 1'b0;
                     dump_last  <= 1'b0;
                     done       <= 1'b1;
`endif
                  end else begin
                     state      <= FETCH;
                     dump_valid <= 1'b0;
                     dump_last  <= 1'b0;
                  end
               end
            end
`ifdef REGDUMP_CHECKSUM_EN
            CSUM: begin
               if (dump_ready) begin
                  state      <= DONE;
                  dump_valid <= 1'b0;
                  dump_last  <= 1'b0;
                  done       <= 1'b1;
               end
            end
`endif
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state      <= IDLE;
               dump_valid <= 1'b0;
               dump_last  <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomized bench: expected word stream is built from the register array contents
// at start, then compared against every handshake of the DUT.
module tb_regfile_dump_reader;

   localparam int N  = 32;
   localparam int NR = 32;
   localparam int AW = 5;
`ifdef REGDUMP_CHECKSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif

   typedef struct {
      logic [N-1:0]  data;
      logic [AW-1:0] index;
      logic          last;
   } word_t;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          dump_ready = 1'b0;
   logic [AW-1:0] rf_read_addr;
   logic [N-1:0]  rf_read_data;
   logic [N-1:0]  dump_data;
   logic [AW-1:0] dump_index;
   logic          dump_valid, dump_last, busy, done;
   logic [N-1:0]  rf [NR];

   logic          start1 = 1'b0;
   logic          ready1 = 1'b0;
   logic [AW-1:0] addr1;
   logic [N-1:0]  rf1_word = '0;
   logic [N-1:0]  data1;
   logic [AW-1:0] index1;
   logic          valid1, last1, busy1, done1;

   int    n_checks = 0;
   int    n_errors = 0;
   word_t exp_q[$];

   always #5 clk = ~clk;

   assign rf_read_data = rf[rf_read_addr];

   regfile_dump_reader #(.N(N), .NUM_REGS(NR), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .start(start),
      .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
      .dump_data(dump_data), .dump_index(dump_index), .dump_valid(dump_valid),
      .dump_ready(dump_ready), .dump_last(dump_last), .busy(busy), .done(done)
   );

   regfile_dump_reader #(.N(N), .NUM_REGS(1), .ADDR_W(AW)) dut1 (
      .clk(clk), .reset(reset), .start(start1),
      .rf_read_addr(addr1), .rf_read_data(rf1_word),
      .dump_data(data1), .dump_index(index1), .dump_valid(valid1),
      .dump_ready(ready1), .dump_last(last1), .busy(busy1), .done(done1)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected stream: every register in order, then the XOR of all of them when enabled.
   function automatic void build_expect();
      logic [N-1:0] x;
      word_t        w;
      exp_q.delete();
      x = '0;
      for (int i = 0; i < NR; i++) begin
         w.data  = rf[i];
         w.index = AW'(i);
         w.last  = (i == NR - 1) && !CSUM;
         exp_q.push_back(w);
         x = x ^ rf[i];
      end
      if (CSUM) begin
         w.data  = x;
         w.index = '0;
         w.last  = 1'b1;
         exp_q.push_back(w);
      end
   endfunction

   // mode 0: ready always high, 1: 1-high/3-low, 2: random. poke: stray start pulses.
   task automatic run_dump(input int mode, input bit poke);
      word_t w, held;
      int    cyc, busy_cnt, hs_cnt, nwords, last_hs_cyc;
      bit    got_done, held_v;
      build_expect();
      nwords = exp_q.size();
      @(negedge clk); start = 1'b1; dump_ready = 1'b0;
      @(negedge clk); start = 1'b0;
      #1;
      check("fetch_busy", busy, 1);
      check("fetch_valid", dump_valid, 0);
      busy_cnt = 1; cyc = 1; hs_cnt = 0; last_hs_cyc = 0;
      got_done = 1'b0; held_v = 1'b0; held = '{default: '0};
      while (!got_done) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         case (mode)
            0:       dump_ready = 1'b1;
            1:       dump_ready = (cyc % 4 == 0);
            default: dump_ready = 1'($urandom_range(0, 1));
         endcase
         #1;
         if (busy) busy_cnt++;
         if (done) begin
            got_done = 1'b1;
            check("done_words", hs_cnt, nwords);
            check("done_timing", cyc, last_hs_cyc + 1);
            if (poke) start = 1'b1;
         end else if (dump_valid) begin
            if (held_v) begin
               check("hold_data", dump_data, held.data);
               check("hold_index", dump_index, held.index);
               check("hold_last", dump_last, held.last);
            end
            if (dump_ready) begin
               if (exp_q.size() == 0) begin
                  check("extra_word", 1, 0);
               end else begin
                  w = exp_q.pop_front();
                  check("data", dump_data, w.data);
                  check("index", dump_index, w.index);
                  check("last", dump_last, w.last);
                  if (hs_cnt < NR) check("rd_addr", rf_read_addr, w.index);
                  if (mode == 0 && hs_cnt < NR) check("hs_cycle", cyc, 2 * (hs_cnt + 1));
               end
               if (poke && hs_cnt == 10) start = 1'b1;
               hs_cnt++;
               last_hs_cyc = cyc;
               held_v = 1'b0;
            end else begin
               held_v     = 1'b1;
               held.data  = dump_data;
               held.index = dump_index;
               held.last  = dump_last;
            end
         end
         if (cyc > 4000) begin
            check("timeout", 1, 0);
            break;
         end
      end
      // FETCH+SEND per register, one CSUM cycle if enabled, plus DONE.
      if (mode == 0) check("busy_cycles", busy_cnt, 2 * NR + int'(CSUM) + 1);
      @(negedge clk); start = 1'b0;
      #1;
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_addr", rf_read_addr, 0);
      check("idle_valid", dump_valid, 0);
      @(negedge clk); #1;
      check("idle_stays", busy, 0);
   endtask

   initial begin
      word_t w;
      word_t e1[$];
      int    cnt;
      bit    seen;

      for (int i = 0; i < NR; i++) rf[i] = N'(i) * 32'h1111_0000;
      #2;
      check("rst_data", dump_data, 0);
      check("rst_index", dump_index, 0);
      check("rst_valid", dump_valid, 0);
      check("rst_last", dump_last, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_addr", rf_read_addr, 0);
      @(negedge clk); reset = 1'b1;

      run_dump(0, 1'b0);
      run_dump(1, 1'b0);
      run_dump(0, 1'b1);

      for (int i = 0; i < NR; i++) rf[i] = $urandom;
      run_dump(2, 1'b0);

      for (int i = 0; i < NR; i++) rf[i] = 32'hA5A5_0000 | N'(i);
      run_dump(2, 1'b0);

      // Reset mid-dump while word 7 is being presented.
      @(negedge clk); start = 1'b1; dump_ready = 1'b1;
      @(negedge clk); start = 1'b0;
      cnt = 0;
      while (!(dump_valid && dump_index == 7) && cnt < 200) begin
         @(negedge clk); #1;
         cnt++;
      end
      check("reach_word7", dump_index, 7);
      reset = 1'b0;
      #1;
      check("abort_data", dump_data, 0);
      check("abort_index", dump_index, 0);
      check("abort_valid", dump_valid, 0);
      check("abort_last", dump_last, 0);
      check("abort_busy", busy, 0);
      check("abort_addr", rf_read_addr, 0);
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk); #1;
         if (done) seen = 1'b1;
      end
      check("abort_no_done", seen, 0);
      reset = 1'b1;
      run_dump(0, 1'b0);

      // Single-register instance.
      rf1_word = 32'hDEAD_BEEF;
      w.data = 32'hDEAD_BEEF; w.index = '0; w.last = !CSUM;
      e1.push_back(w);
      if (CSUM) begin
         w.last = 1'b1;
         e1.push_back(w);
      end
      @(negedge clk); start1 = 1'b1; ready1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      cnt = 0; seen = 1'b0;
      while (!seen && cnt < 20) begin
         @(negedge clk); #1;
         cnt++;
         if (done1) seen = 1'b1;
         else if (valid1) begin
            if (e1.size() == 0) check("one_extra", 1, 0);
            else begin
               w = e1.pop_front();
               check("one_data", data1, w.data);
               check("one_index", index1, w.index);
               check("one_last", last1, w.last);
            end
         end
      end
      check("one_done", seen, 1);
      check("one_all_words", e1.size(), 0);
      check("one_addr", addr1, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
